// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-back, write-allocate data cache.
// Geometry is 8 lines x 16 bytes. Misses fetch or evict whole 16-byte blocks
// over a request/busywait handshake, and the pipeline is stalled meanwhile.
module data_cache (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         READ,
  input  logic         WRITE,
  input  logic [2:0]   FUNCT3,
  input  logic [31:0]  ADDRESS,
  input  logic [31:0]  WRITEDATA,
  output logic [31:0]  READDATA,
  output logic         BUSYWAIT,
  output logic         MEM_READ,
  output logic         MEM_WRITE,
  output logic [27:0]  MEM_ADDRESS,
  output logic [127:0] MEM_WRITEDATA,
  input  logic [127:0] MEM_READDATA,
  input  logic         MEM_BUSYWAIT
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2,
    UPDATE    = 2'd3
  } state_t;

  state_t state_r;
  state_t state_next_s;

  // Per-line bookkeeping; tags and data are deliberately not reset.
  logic [7:0]   valid_r;
  logic [7:0]   dirty_r;
  logic [24:0]  tag_r  [0:7];
  logic [127:0] data_r [0:7];
  logic [127:0] fill_r;

  logic [3:0]   offset_s;
  logic [2:0]   index_s;
  logic [24:0]  tag_s;
  logic         access_s;
  logic         hit_s;
  logic [127:0] line_s;
  logic [31:0]  word_s;
  logic [7:0]   byte_s;
  logic [15:0]  half_s;
  logic [31:0]  load_s;
  logic [15:0]  store_mask_s;
  logic [31:0]  store_word_s;
  logic         store_en_s;
  logic [127:0] merged_s;
  logic         fill_done_s;

  assign offset_s    = ADDRESS[3:0];
  assign index_s     = ADDRESS[6:4];
  assign tag_s       = ADDRESS[31:7];
  assign access_s    = READ | WRITE;
  assign line_s      = data_r[index_s];
  assign hit_s       = valid_r[index_s] & (tag_r[index_s] == tag_s);
  assign word_s      = line_s[{offset_s[3:2], 5'b00000} +: 32];
  assign byte_s      = word_s[{ADDRESS[1:0], 3'b000} +: 8];
  assign half_s      = word_s[{ADDRESS[1], 4'b0000} +: 16];
  assign fill_done_s = (state_r == ALLOCATE) & ~MEM_BUSYWAIT;
  // A store only counts when it actually touches at least one byte.
  assign store_en_s  = (state_r == IDLE) & WRITE & hit_s & (|store_mask_s);

  // Load lane selection and sign/zero extension
  always_comb begin
    load_s = word_s;
    case (FUNCT3)
      3'b000:  load_s = {{24{byte_s[7]}}, byte_s};
      3'b100:  load_s = {24'h000000, byte_s};
      3'b001:  load_s = {{16{half_s[15]}}, half_s};
      3'b101:  load_s = {16'h0000, half_s};
      default: load_s = word_s;
    endcase
  end

  // Store byte-enable mask and lane-replicated store data
  always_comb begin
    store_mask_s = 16'h0000;
    store_word_s = WRITEDATA;
    case (FUNCT3)
      3'b000: begin
        store_mask_s = 16'h0001 << offset_s;
        store_word_s = {4{WRITEDATA[7:0]}};
      end
      3'b001: begin
        store_mask_s = 16'h0003 << {offset_s[3:1], 1'b0};
        store_word_s = {2{WRITEDATA[15:0]}};
      end
      3'b010: begin
        store_mask_s = 16'h000F << {offset_s[3:2], 2'b00};
        store_word_s = WRITEDATA;
      end
      default: begin
        store_mask_s = 16'h0000;
        store_word_s = WRITEDATA;
      end
    endcase
  end

  // Merge enabled store bytes into the addressed line
  always_comb begin
    merged_s = line_s;
    for (int b = 32'sd0; b < 32'sd16; b++) begin
      if (store_mask_s[b]) begin
        merged_s[{b[3:0], 3'b000} +: 8] = store_word_s[{b[1:0], 3'b000} +: 8];
      end else begin
        merged_s[{b[3:0], 3'b000} +: 8] = line_s[{b[3:0], 3'b000} +: 8];
      end
    end
  end

  // FSM state register; reset aborts any transfer in flight
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic for miss handling
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (access_s && !hit_s) begin
          if (valid_r[index_s] && dirty_r[index_s]) begin
            state_next_s = WRITEBACK;
          end else begin
            state_next_s = ALLOCATE;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      WRITEBACK: begin
        if (!MEM_BUSYWAIT) begin
          state_next_s = ALLOCATE;
        end else begin
          state_next_s = WRITEBACK;
        end
      end
      ALLOCATE: begin
        if (!MEM_BUSYWAIT) begin
          state_next_s = UPDATE;
        end else begin
          state_next_s = ALLOCATE;
        end
      end
      UPDATE:  state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Memory-side request outputs, decoded from the state register only
  always_comb begin
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = 28'h0000000;
    MEM_WRITEDATA = 128'h0;
    case (state_r)
      WRITEBACK: begin
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = {tag_r[index_s], index_s};
        MEM_WRITEDATA = line_s;
      end
      ALLOCATE: begin
        MEM_READ    = 1'b1;
        MEM_ADDRESS = ADDRESS[31:4];
      end
      default: begin
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_ADDRESS   = 28'h0000000;
        MEM_WRITEDATA = 128'h0;
      end
    endcase
  end

  // CPU-side stall and load result; both forced low while in reset
  always_comb begin
    BUSYWAIT = ~RESET & ((state_r != IDLE) | (access_s & ~hit_s));
    if (!RESET && (state_r == IDLE) && READ && !WRITE && hit_s) begin
      READDATA = load_s;
    end else begin
      READDATA = 32'h00000000;
    end
  end

  // Capture the fetched block on allocate completion
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      fill_r <= 128'h0;
    end else if (fill_done_s) begin
      fill_r <= MEM_READDATA;
    end else begin
      fill_r <= fill_r;
    end
  end

  // Valid/dirty flags: cleared by reset, set by refill and stores
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      valid_r <= 8'h00;
      dirty_r <= 8'h00;
    end else if (state_r == UPDATE) begin
      valid_r[index_s] <= 1'b1;
      dirty_r[index_s] <= 1'b0;
    end else if (store_en_s) begin
      dirty_r[index_s] <= 1'b1;
    end else begin
      valid_r <= valid_r;
      dirty_r <= dirty_r;
    end
  end

  // Tag and data storage: refill whole line, or merge a store hit
  always_ff @(posedge CLK) begin
    if (state_r == UPDATE) begin
      data_r[index_s] <= fill_r;
      tag_r[index_s]  <= tag_s;
    end else if (store_en_s) begin
      data_r[index_s] <= merged_s;
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: directed vector table and hand-written miss/reset sequences,
// then randomized accesses checked against a flat byte-memory reference model.
module tb_data_cache;

  logic         CLK;
  logic         RESET;
  logic         READ;
  logic         WRITE;
  logic [2:0]   FUNCT3;
  logic [31:0]  ADDRESS;
  logic [31:0]  WRITEDATA;
  logic [31:0]  READDATA;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic         MEM_WRITE;
  logic [27:0]  MEM_ADDRESS;
  logic [127:0] MEM_WRITEDATA;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;

  data_cache dut (
    .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE), .FUNCT3(FUNCT3),
    .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .READDATA(READDATA),
    .BUSYWAIT(BUSYWAIT), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
    .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITEDATA(MEM_WRITEDATA),
    .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int checks = 0;
  int failures = 0;
  int lat = 5;

  // Backing memory (updated by write-backs) and architectural overlay
  // (every byte the CPU has stored since the last reset).
  logic [7:0] mem_b  [logic [31:0]];
  logic [7:0] arch_b [logic [31:0]];

  // Residency model: which block each index currently holds.
  bit          r_valid [8];
  bit          r_dirty [8];
  logic [24:0] r_tag   [8];

  typedef struct { bit w; logic [27:0] a; logic [127:0] d; } req_t;
  req_t req_log[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] dflt(input logic [31:0] a);
    if (a >= 32'h40 && a < 32'h50) return a[7:0] - 8'h40;
    return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'hA5;
  endfunction

  function automatic logic [31:0] dword(input logic [31:0] a);
    return {dflt(a + 32'd3), dflt(a + 32'd2), dflt(a + 32'd1), dflt(a)};
  endfunction

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    if (mem_b.exists(a)) return mem_b[a];
    return dflt(a);
  endfunction

  function automatic logic [7:0] arch_rd(input logic [31:0] a);
    if (arch_b.exists(a)) return arch_b[a];
    return mem_rd(a);
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] wa;
    logic [31:0] ha;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] w;
    wa = a & 32'hFFFF_FFFC;
    ha = a & 32'hFFFF_FFFE;
    b  = arch_rd(a);
    h  = {arch_rd(ha + 32'd1), arch_rd(ha)};
    w  = {arch_rd(wa + 32'd3), arch_rd(wa + 32'd2), arch_rd(wa + 32'd1), arch_rd(wa)};
    case (f3)
      3'b000:  return (b >= 8'h80) ? 32'(b) - 32'h100 : 32'(b);
      3'b100:  return 32'(b);
      3'b001:  return (h >= 16'h8000) ? 32'(h) - 32'h1_0000 : 32'(h);
      3'b101:  return 32'(h);
      default: return w;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      r_valid[i] = 1'b0;
      r_dirty[i] = 1'b0;
    end
    arch_b.delete();
  endtask

  // Memory responder: each request is held for 'lat' cycles, the last one
  // with MEM_BUSYWAIT low; write-backs are checked against the model.
  initial begin
    int          cnt;
    bit          done_prev;
    logic [127:0] exp_blk;
    logic [31:0] base;
    cnt = 0;
    done_prev = 1'b0;
    MEM_BUSYWAIT = 1'b1;
    MEM_READDATA = 128'h0;
    forever begin
      @(negedge CLK);
      if (done_prev) cnt = 0;
      done_prev = 1'b0;
      if (MEM_READ || MEM_WRITE) begin
        cnt++;
        base = {MEM_ADDRESS, 4'b0000};
        if (cnt == 1) begin
          req_log.push_back('{MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA});
          chk("rd_wr_exclusive", 128'(MEM_READ & MEM_WRITE), 128'd0);
          if (MEM_WRITE) begin
            for (int k = 0; k < 16; k++) exp_blk[8*k +: 8] = arch_rd(base + 32'(k));
            chk("wb_block", MEM_WRITEDATA, exp_blk);
          end
        end
        for (int k = 0; k < 16; k++) MEM_READDATA[8*k +: 8] = mem_rd(base + 32'(k));
        MEM_BUSYWAIT = (cnt < lat);
        if (cnt >= lat) begin
          done_prev = 1'b1;
          if (MEM_WRITE) begin
            for (int k = 0; k < 16; k++) mem_b[base + 32'(k)] = MEM_WRITEDATA[8*k +: 8];
          end
        end
      end else begin
        cnt = 0;
        MEM_BUSYWAIT = 1'b1;
      end
    end
  end

  // One CPU access: updates the model, drives the DUT, counts stall cycles.
  // Called just after a posedge; returns just after a posedge.
  task automatic run_op(input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int stall, output logic [31:0] rdata,
                        output int m_stall, output logic [31:0] m_rdata);
    int          idx;
    logic [24:0] tg;
    logic [31:0] wa;
    logic [31:0] ha;
    idx = int'(a[6:4]);
    tg  = a[31:7];
    wa  = a & 32'hFFFF_FFFC;
    ha  = a & 32'hFFFF_FFFE;
    if (r_valid[idx] && r_tag[idx] == tg) m_stall = 0;
    else if (r_valid[idx] && r_dirty[idx]) m_stall = 2 * lat + 2;
    else m_stall = lat + 2;
    if (m_stall != 0) begin
      r_valid[idx] = 1'b1;
      r_tag[idx]   = tg;
      r_dirty[idx] = 1'b0;
    end
    m_rdata = model_load(f3, a);
    if (wr) begin
      case (f3)
        3'b000: begin arch_b[a] = wd[7:0]; r_dirty[idx] = 1'b1; end
        3'b001: begin
          arch_b[ha] = wd[7:0];
          arch_b[ha + 32'd1] = wd[15:8];
          r_dirty[idx] = 1'b1;
        end
        3'b010: begin
          for (int k = 0; k < 4; k++) arch_b[wa + 32'(k)] = wd[8*k +: 8];
          r_dirty[idx] = 1'b1;
        end
        default: ;
      endcase
    end
    ADDRESS = a; FUNCT3 = f3; WRITEDATA = wd; READ = rd; WRITE = wr;
    #1;
    stall = 0;
    while (BUSYWAIT === 1'b1 && stall <= 200) begin
      @(posedge CLK); #1;
      stall++;
    end
    if (stall > 200) chk("busywait_timeout", 128'd1, 128'd0);
    rdata = READDATA;
    @(posedge CLK); #1;
    READ = 1'b0; WRITE = 1'b0;
  endtask

  typedef struct {
    bit rd; bit wr; logic [2:0] f3; logic [31:0] addr; logic [31:0] wd;
    bit chk_rd; logic [31:0] exp_rd; int exp_stall;
  } vec_t;

  initial begin
    vec_t        vecs[$];
    int          stall;
    int          m_stall;
    logic [31:0] rdata;
    logic [31:0] m_rdata;
    string       nm;

    // Directed vectors at memory latency 5
    vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h40, 32'h0,        1'b1, 32'h03020100, 7});
    vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h40, 32'h0,        1'b1, 32'h03020100, 0});
    vecs.push_back('{1'b0, 1'b1, 3'b000, 32'h43, 32'h83,       1'b0, 32'h0,        0});
    vecs.push_back('{1'b1, 1'b0, 3'b000, 32'h43, 32'h0,        1'b1, 32'hFFFFFF83, 0});
    vecs.push_back('{1'b1, 1'b0, 3'b100, 32'h43, 32'h0,        1'b1, 32'h00000083, 0});
    vecs.push_back('{1'b1, 1'b0, 3'b001, 32'h42, 32'h0,        1'b1, 32'hFFFF8302, 0});
    vecs.push_back('{1'b1, 1'b0, 3'b101, 32'h42, 32'h0,        1'b1, 32'h00008302, 0});
    vecs.push_back('{1'b0, 1'b1, 3'b010, 32'h44, 32'hDEADBEEF, 1'b0, 32'h0,        0});
    vecs.push_back('{1'b0, 1'b1, 3'b000, 32'h45, 32'h00000055, 1'b0, 32'h0,        0});
    vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h44, 32'h0,        1'b1, 32'hDEAD55EF, 0});
    vecs.push_back('{1'b1, 1'b1, 3'b010, 32'h48, 32'h11223344, 1'b0, 32'h0,        0});
    vecs.push_back('{1'b1, 1'b0, 3'b010, 32'h48, 32'h0,        1'b1, 32'h11223344, 0});
    vecs.push_back('{1'b1, 1'b0, 3'b011, 32'h4C, 32'h0,        1'b1, 32'h0F0E0D0C, 0});
    vecs.push_back('{1'b1, 1'b0, 3'b010, 32'hC4, 32'h0,        1'b1, dword(32'hC4), 12});

    RESET = 1'b1; READ = 1'b0; WRITE = 1'b0;
    FUNCT3 = 3'b000; ADDRESS = 32'h0; WRITEDATA = 32'h0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_busywait", 128'(BUSYWAIT), 128'd0);
    chk("rst_mem_read", 128'(MEM_READ), 128'd0);
    chk("rst_mem_write", 128'(MEM_WRITE), 128'd0);
    chk("rst_mem_address", 128'(MEM_ADDRESS), 128'd0);
    chk("rst_mem_writedata", MEM_WRITEDATA, 128'd0);
    chk("rst_readdata", 128'(READDATA), 128'd0);
    RESET = 1'b0;
    @(posedge CLK); #1;
    model_reset();
    lat = 5;

    foreach (vecs[i]) begin
      run_op(vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wd,
             stall, rdata, m_stall, m_rdata);
      nm = $sformatf("vec%0d_stall", i);
      chk(nm, 128'(stall), 128'(vecs[i].exp_stall));
      if (vecs[i].chk_rd) begin
        nm = $sformatf("vec%0d_readdata", i);
        chk(nm, 128'(rdata), 128'(vecs[i].exp_rd));
      end
    end

    // Memory traffic of the directed table: first fill, then dirty eviction
    chk("log_size", 128'(req_log.size()), 128'd3);
    if (req_log.size() >= 3) begin
      chk("fill_is_read", 128'(req_log[0].w), 128'd0);
      chk("fill_addr", 128'(req_log[0].a), 128'h4);
      chk("evict_is_write", 128'(req_log[1].w), 128'd1);
      chk("evict_addr", 128'(req_log[1].a), 128'h4);
      chk("evict_bytes4_7", 128'(req_log[1].d[63:32]), 128'hDEAD55EF);
      chk("refill_is_read", 128'(req_log[2].w), 128'd0);
      chk("refill_addr", 128'(req_log[2].a), 128'hC);
    end

    // Store miss on an invalid line, then evict it and read it back
    req_log.delete();
    run_op(1'b0, 1'b1, 3'b001, 32'h102, 32'h0000BEEF, stall, rdata, m_stall, m_rdata);
    chk("sh_miss_stall", 128'(stall), 128'd7);
    run_op(1'b1, 1'b0, 3'b010, 32'h182, 32'h0, stall, rdata, m_stall, m_rdata);
    chk("sh_evict_stall", 128'(stall), 128'd12);
    chk("sh_evict_log", 128'(req_log.size()), 128'd3);
    if (req_log.size() >= 3) begin
      chk("sh_wb_addr", 128'(req_log[1].a), 128'h10);
      chk("sh_wb_bytes2_3", 128'(req_log[1].d[31:16]), 128'hBEEF);
      chk("sh_refill_addr", 128'(req_log[2].a), 128'h18);
    end
    run_op(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, stall, rdata, m_stall, m_rdata);
    chk("sh_reload_stall", 128'(stall), 128'd7);
    chk("sh_reload_data", 128'(rdata), 128'h0000BEEF);

    // Reset pulse in the middle of an allocate
    ADDRESS = 32'h200; FUNCT3 = 3'b010; WRITEDATA = 32'h0; READ = 1'b1; WRITE = 1'b0;
    @(posedge CLK); #1;
    chk("alloc_mem_read", 128'(MEM_READ), 128'd1);
    chk("alloc_mem_address", 128'(MEM_ADDRESS), 128'h20);
    #1 RESET = 1'b1;
    #1;
    chk("abort_mem_read", 128'(MEM_READ), 128'd0);
    chk("abort_busywait", 128'(BUSYWAIT), 128'd0);
    @(posedge CLK); #1;
    READ = 1'b0;
    RESET = 1'b0;
    model_reset();
    @(posedge CLK); #1;
    run_op(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, stall, rdata, m_stall, m_rdata);
    chk("post_abort_stall", 128'(stall), 128'd7);
    chk("post_abort_data", 128'(rdata), 128'(dword(32'h200)));

    // Randomized accesses against the reference model
    for (int i = 0; i < 300; i++) begin
      bit          isw;
      logic [2:0]  f3;
      logic [31:0] a;
      lat = $urandom_range(1, 4);
      isw = 1'($urandom_range(0, 1));
      if (isw) begin
        f3 = 3'($urandom_range(0, 2));
      end else begin
        case ($urandom_range(0, 5))
          0: f3 = 3'b000;
          1: f3 = 3'b001;
          2: f3 = 3'b010;
          3: f3 = 3'b100;
          4: f3 = 3'b101;
          default: f3 = 3'b011;
        endcase
      end
      a = 32'($urandom_range(0, 3)) * 32'h80 + 32'($urandom_range(0, 127));
      if (f3[1:0] == 2'b01) a[0] = 1'b0;
      if (f3[1] == 1'b1) a[1:0] = 2'b00;
      run_op(!isw, isw, f3, a, $urandom(), stall, rdata, m_stall, m_rdata);
      nm = $sformatf("rnd%0d_stall", i);
      chk(nm, 128'(stall), 128'(m_stall));
      if (!isw) begin
        nm = $sformatf("rnd%0d_readdata a=%0h f3=%0d", i, a, f3);
        chk(nm, 128'(rdata), 128'(m_rdata));
      end
      if ($urandom_range(0, 3) == 0) begin
        @(posedge CLK); #1;
        chk("idle_busywait", 128'(BUSYWAIT), 128'd0);
        chk("idle_mem_req", 128'(MEM_READ | MEM_WRITE), 128'd0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_cache.md
# data_cache

Direct-mapped, write-back, write-allocate data cache between the pipeline MEM stage and the block-organised data memory. It accepts byte, halfword and word loads and stores from the CPU, including sign/zero extension. It stalls the pipeline through BUSYWAIT on misses and fetches or evicts 16-byte blocks over a request/busywait handshake with main memory.

## Interface
- No parameters. Geometry is fixed at 8 lines × 16 bytes (128 B).
- ADDRESS split: offset = ADDRESS[3:0], index = ADDRESS[6:4], tag = ADDRESS[31:7] (25 b).
- CLK  in  1  clock.
- RESET  in  1  reset; asynchronous, active-high.
- READ  in  1  CPU load request.
- WRITE  in  1  CPU store request.
- FUNCT3  in  3  access size and sign (RV32 load/store funct3).
- ADDRESS  in  32  CPU byte address.
- WRITEDATA  in  32  store data; the low bytes are used for SB/SH.
- READDATA  out  32  load result, already extended.
- BUSYWAIT  out  1  stall request to the pipeline.
- MEM_READ  out  1  block fetch request.
- MEM_WRITE  out  1  block write-back request.
- MEM_ADDRESS  out  28  block address, i.e. byte address[31:4].
- MEM_WRITEDATA  out  128  evicted block; byte 0 is at [7:0].
- MEM_READDATA  in  128  fetched block; same byte order.
- MEM_BUSYWAIT  in  1  memory busy; a transfer completes at a posedge where this input is 0 while the request is held.

## Operation
- Per line state: valid, dirty, 25-bit tag, 128-bit data. Storage is little-endian: byte k of the line is at data[8k+7:8k].
- hit = valid[index] and (tag[index] == ADDRESS tag). Hit is combinational.
- Load extraction, using the word at offset[3:2]:
  - LB 000 and LBU 100 select the byte at ADDRESS[1:0].
  - LH 001 and LHU 101 select the half at ADDRESS[1].
  - LW 010 ignores ADDRESS[1:0].
  - Signed loads sign-extend; unsigned loads zero-extend.
  - Any other FUNCT3 returns the full word.
- Store, on a hit in IDLE at posedge: SB writes 1 byte, SH writes 2 bytes, SW writes 4 bytes, using the same lane selection as loads. The store sets dirty[index]=1. Any other FUNCT3 writes nothing.
- READ and WRITE asserted together: treated as WRITE; READDATA is don't-care.
- FSM states:
  - IDLE:
    - (READ|WRITE) and hit: service the access. Stay in IDLE.
    - (READ|WRITE) and miss with valid and dirty: go to WRITEBACK.
    - (READ|WRITE) and miss otherwise: go to ALLOCATE.
  - WRITEBACK:
    - Outputs: MEM_WRITE=1, MEM_ADDRESS={old tag, index}, MEM_WRITEDATA=line data.
    - On completion, go to ALLOCATE.
  - ALLOCATE:
    - Outputs: MEM_READ=1, MEM_ADDRESS=ADDRESS[31:4].
    - On completion, capture MEM_READDATA and go to UPDATE.
  - UPDATE:
    - Write the captured block, the new tag, valid=1 and dirty=0.
    - Go to IDLE. The retried access then hits.
- BUSYWAIT = (state≠IDLE) or ((READ|WRITE) and not hit).
- MEM_READ and MEM_WRITE are never both 1.
- READDATA and MEM_* outputs are held stable while BUSYWAIT=1.
- The CPU holds READ, WRITE, ADDRESS, FUNCT3 and WRITEDATA stable while BUSYWAIT=1.

## Timing
- Reset values:
  - State IDLE; all valid=0 and dirty=0.
  - BUSYWAIT=0, MEM_READ=0, MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITEDATA=0, READDATA=0.
  - Tags and line data are not cleared.
- RESET asserted mid-miss: the FSM aborts immediately and requests drop asynchronously. No line is modified by the aborted transfer.
- Hit: zero stall. READDATA is valid in the same cycle. A store commits at that cycle's posedge.
- Definitions: Lr and Lw = number of cycles the read or write request is held, counting up to and including the completion cycle.
- Clean miss: BUSYWAIT high for Lr+2 cycles (1 IDLE detect + Lr ALLOCATE + 1 UPDATE). BUSYWAIT falls in the IDLE cycle that hits.
- Dirty miss: BUSYWAIT high for Lw+Lr+2 cycles.
- Back-to-back hits to different lines sustain one access per cycle.
- A request deasserted while in IDLE with no pending miss leaves the cache idle.

## Test plan
- Reset, then LW 0x0000_0040 with the memory block holding 0x03020100…0F0E0D0C and L=5:
  - MEM_READ asserted with MEM_ADDRESS=0x000_0004.
  - BUSYWAIT high for 7 cycles.
  - READDATA=0x03020100.
  - An immediate repeat LW has zero stall.
- After that fill, loads from 0x43 with byte 0x83 at that address:
  - LB returns 0xFFFFFF83.
  - LBU returns 0x00000083.
  - LH at 0x42 returns 0xFFFF8302.
  - LHU at 0x42 returns 0x00008302.
- Store hit: SW 0xDEADBEEF at 0x44, then SB 0x55 at 0x45, then LW 0x44 → 0xDEAD55EF, with no stalls and no MEM_* activity.
- Dirty eviction: after the store test, LW 0x0000_00C4 (same index 4, different tag):
  - MEM_WRITE asserted first, with MEM_ADDRESS=0x000_0004 and MEM_WRITEDATA bytes 4–7 = EF,55,AD,DE.
  - MEM_READ follows with MEM_ADDRESS=0x000_000C.
  - BUSYWAIT high for 12 cycles (L=5).
- Store miss on a clean invalid line, SH 0xBEEF at 0x102: the block is fetched, then the store is written. A later eviction of that line writes back bytes 2–3 = EF,BE.
- RESET pulse during ALLOCATE:
  - MEM_READ and BUSYWAIT drop to 0 asynchronously.
  - A following LW to the same address misses again, with a full Lr+2 stall.
